// File: rtl/satatb_txsched.sv
// satatb_txsched: serialises upstream dwords into 9-bit {K,byte} symbols with ALIGN bursts and SYNC fill.
// Latency: byte 0 appears one clock after the S_VALID && S_READY transfer; one symbol leaves every clock.
// Backpressure: S_READY only on dword boundaries outside ALIGN bursts; SATATB_CONT_EN adds SYNC/CONT/junk fill runs.
module satatb_txsched #(
  parameter int ALIGN_INTERVAL = 256,
  parameter int ALIGN_COUNT    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [31:0] S_DATA,
  input  logic        S_PRIM,
  output logic [8:0]  M_DATA,
  output logic        M_FIRST,
  output logic        o_align
);
  localparam int DW = $clog2(ALIGN_INTERVAL + 1);
  localparam int AW = $clog2(ALIGN_COUNT + 1);
  localparam logic [DW-1:0] DCNT_MAX  = DW'(ALIGN_INTERVAL);
  localparam logic [AW-1:0] AREM_INIT = AW'(ALIGN_COUNT);

  localparam logic [1:0] SRC_ALIGN = 2'd0;
  localparam logic [1:0] SRC_DATA  = 2'd1;
  localparam logic [1:0] SRC_SYNC  = 2'd2;
`ifdef SATATB_CONT_EN
  localparam logic [1:0] SRC_CONT  = 2'd3;
`endif

  logic [1:0]    bcnt;
  logic [1:0]    src, src_n;
  logic [31:0]   word, word_n;
  logic          prim, prim_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [AW-1:0] arem, arem_n;
`ifdef SATATB_CONT_EN
  logic [1:0]    run, run_n;    // fillers sent in the current run, saturating at 3
  logic [31:0]   jcnt, jcnt_n;
`endif

  function automatic logic [8:0] sym(input logic [1:0] s, input logic [1:0] idx,
                                     input logic [31:0] w, input logic p);
    logic [8:0] r;
    r = 9'h000;
    case (s)
      SRC_ALIGN: begin
        case (idx)
          2'd0:       r = 9'h1BC;
          2'd1, 2'd2: r = 9'h04A;
          default:    r = 9'h07B;
        endcase
      end
      SRC_DATA: begin
        r = {p && (idx == 2'd0), w[{idx, 3'b000} +: 8]};
      end
`ifdef SATATB_CONT_EN
      SRC_CONT: begin
        case (idx)
          2'd0:    r = 9'h17C;
          2'd1:    r = 9'h0AA;
          default: r = 9'h099;
        endcase
      end
`endif
      default: begin
        case (idx)
          2'd0:    r = 9'h17C;
          2'd1:    r = 9'h095;
          default: r = 9'h0B5;
        endcase
      end
    endcase
    return r;
  endfunction

  assign S_READY = !i_reset && (bcnt == 2'd3) && (arem == '0);

  always_comb begin
    src_n  = src;
    word_n = word;
    prim_n = prim;
    dcnt_n = dcnt;
    arem_n = arem;
`ifdef SATATB_CONT_EN
    run_n  = run;
    jcnt_n = jcnt;
`endif
    if (bcnt == 2'd3) begin
      if (arem != '0) begin
        src_n  = SRC_ALIGN;
        arem_n = arem - 1'b1;
        dcnt_n = '0;
      end else begin
        dcnt_n = dcnt + 1'b1;
        // The burst is armed here and starts at the next boundary, so dcnt never wraps.
        if (dcnt_n == DCNT_MAX) arem_n = AREM_INIT;
        if (S_VALID) begin
          src_n  = SRC_DATA;
          word_n = S_DATA;
          prim_n = S_PRIM;
`ifdef SATATB_CONT_EN
          run_n  = 2'd0;
`endif
        end else begin
`ifdef SATATB_CONT_EN
          case (run)
            2'd0, 2'd1: src_n = SRC_SYNC;
            2'd2:       src_n = SRC_CONT;
            default: begin
              // Junk fill reuses the data path with the counter as payload.
              src_n  = SRC_DATA;
              word_n = jcnt;
              prim_n = 1'b0;
              jcnt_n = jcnt + 32'd1;
            end
          endcase
          if (run != 2'd3) run_n = run + 2'd1;
`else
          src_n = SRC_SYNC;
`endif
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bcnt    <= 2'd3;
      src     <= SRC_ALIGN;
      word    <= 32'd0;
      prim    <= 1'b0;
      dcnt    <= '0;
      arem    <= AREM_INIT;
      M_DATA  <= 9'h07B;
      M_FIRST <= 1'b0;
      o_align <= 1'b0;
`ifdef SATATB_CONT_EN
      run     <= 2'd0;
      jcnt    <= 32'd0;
`endif
    end else begin
      bcnt    <= bcnt + 2'd1;
      src     <= src_n;
      word    <= word_n;
      prim    <= prim_n;
      dcnt    <= dcnt_n;
      arem    <= arem_n;
      M_DATA  <= sym(src_n, bcnt + 2'd1, word_n, prim_n);
      M_FIRST <= (bcnt == 2'd3);
      o_align <= (src_n == SRC_ALIGN);
`ifdef SATATB_CONT_EN
      run     <= run_n;
      jcnt    <= jcnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_satatb_txsched.sv
// Bench for satatb_txsched: dword-slot reference model feeding a symbol scoreboard, plus a data vector table.
`timescale 1ns/1ps
module tb_satatb_txsched;
  localparam int AI = 4;
  localparam int AC = 2;

  localparam logic [35:0] ALIGN_S = {9'h07B, 9'h04A, 9'h04A, 9'h1BC};
  localparam logic [35:0] SYNC_S  = {9'h0B5, 9'h0B5, 9'h095, 9'h17C};
  localparam logic [35:0] CONT_S  = {9'h099, 9'h099, 9'h0AA, 9'h17C};

  logic        clk = 1'b0;
  logic        i_reset;
  logic        S_VALID;
  logic        S_READY;
  logic [31:0] S_DATA;
  logic        S_PRIM;
  logic [8:0]  M_DATA;
  logic        M_FIRST;
  logic        o_align;

  always #5 clk = ~clk;

  satatb_txsched #(.ALIGN_INTERVAL(AI), .ALIGN_COUNT(AC)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .S_DATA  (S_DATA),
    .S_PRIM  (S_PRIM),
    .M_DATA  (M_DATA),
    .M_FIRST (M_FIRST),
    .o_align (o_align)
  );

  typedef struct packed {
    logic [8:0] sym;
    logic       first;
    logic       align;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic        p;
    logic [8:0]  e0, e1, e2, e3;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        tbl[6];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          bpos;       // byte index M_DATA is showing this cycle
  int          k_slot;     // index of the next dword slot since reset
  int          run_m;
  logic [31:0] junk_m;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h, expected %03h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [35:0] dsym(input logic [31:0] d, input logic p);
    return {1'b0, d[31:24], 1'b0, d[23:16], 1'b0, d[15:8], p, d[7:0]};
  endfunction

  task automatic push4(input logic [35:0] syms, input logic al);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.sym   = syms[9*i +: 9];
      e.first = (i == 0);
      e.align = al;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_filler();
`ifdef SATATB_CONT_EN
    run_m++;
    if (run_m <= 2) push4(SYNC_S, 1'b0);
    else if (run_m == 3) push4(CONT_S, 1'b0);
    else begin
      push4(dsym(junk_m, 1'b0), 1'b0);
      junk_m++;
    end
`else
    push4(SYNC_S, 1'b0);
`endif
  endtask

  // ALIGN slots recur with a fixed period regardless of traffic.
  function automatic logic is_align_slot(input int k);
    return (k % (AC + AI)) < AC;
  endfunction

  task automatic tick(input logic v, input logic [31:0] d, input logic p,
                      input logic [35:0] dsyms, output logic taken);
    logic exp_rdy;
    exp_t e;
    taken   = 1'b0;
    exp_rdy = 1'b0;
    S_VALID = v;
    S_DATA  = d;
    S_PRIM  = p;
    if (bpos == 3) begin
      if (is_align_slot(k_slot)) begin
        push4(ALIGN_S, 1'b1);
      end else begin
        exp_rdy = 1'b1;
        if (v) begin
          push4(dsyms, 1'b0);
          taken = 1'b1;
          run_m = 0;
        end else begin
          push_filler();
        end
      end
      k_slot++;
    end
    @(negedge clk);
    chk("s_ready", 9'(S_READY), 9'(exp_rdy));
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got symbol %03h, expected none queued (cycle %0d)", M_DATA, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("m_data", M_DATA, e.sym);
      chk("m_first", 9'(M_FIRST), 9'(e.first));
      chk("o_align", 9'(o_align), 9'(e.align));
    end
    @(posedge clk);
    #1;
    cyc++;
    bpos = (bpos + 1) % 4;
  endtask

  task automatic idle(input int n);
    logic t;
    repeat (n) tick(1'b0, $urandom, 1'b0, 36'd0, t);
  endtask

  task automatic do_reset();
    exp_t e;
    i_reset = 1'b1;
    S_VALID = 1'b0;
    S_PRIM  = 1'b0;
    S_DATA  = 32'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_m_data", M_DATA, 9'h07B);
      chk("rst_m_first", 9'(M_FIRST), 9'd0);
      chk("rst_o_align", 9'(o_align), 9'd0);
      chk("rst_s_ready", 9'(S_READY), 9'd0);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    exp_q.delete();
    e.sym   = 9'h07B;
    e.first = 1'b0;
    e.align = 1'b0;
    exp_q.push_back(e);
    bpos   = 3;
    k_slot = 0;
    run_m  = 0;
    junk_m = 32'd0;
  endtask

  // Holds the dword until the model's boundary accepts it, then toggles S_VALID
  // randomly until the next boundary to show off-boundary inputs are ignored.
  task automatic send_dword(input logic [31:0] d, input logic p, input logic [35:0] es);
    logic taken;
    int   guard;
    taken = 1'b0;
    guard = 0;
    while (!taken && guard < 64) begin
      tick(1'b1, d, p, es, taken);
      guard++;
    end
    while (bpos != 3) tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 36'd0, taken);
  endtask

  initial begin
    logic        taken;
    logic [31:0] pay;
    int          guard;

    tbl[0] = '{32'hDDCCBBAA, 1'b0, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD};
    tbl[1] = '{32'hDDCCBBAA, 1'b1, 9'h1AA, 9'h0BB, 9'h0CC, 9'h0DD};
    tbl[2] = '{32'h00000000, 1'b0, 9'h000, 9'h000, 9'h000, 9'h000};
    tbl[3] = '{32'hFFFFFFFF, 1'b1, 9'h1FF, 9'h0FF, 9'h0FF, 9'h0FF};
    tbl[4] = '{32'h12345678, 1'b0, 9'h078, 9'h056, 9'h034, 9'h012};
    tbl[5] = '{32'h0000BC7C, 1'b1, 9'h17C, 9'h0BC, 9'h000, 9'h000};

    i_reset = 1'b1;
    S_VALID = 1'b0;
    S_PRIM  = 1'b0;
    S_DATA  = 32'd0;
    do_reset();

    // Idle stream long enough to cross an ALIGN burst inside a filler run.
    idle(40);

    foreach (tbl[i])
      send_dword(tbl[i].d, tbl[i].p, {tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0});

    // Back-to-back data across several ALIGN bursts.
    pay = 32'h10203040;
    repeat (48) begin
      tick(1'b1, pay, 1'b0, dsym(pay, 1'b0), taken);
      if (taken) pay++;
    end

    // Filler run restarts after data.
    idle(32);

    // Reset while the second byte of a data dword is on M_DATA.
    taken = 1'b0;
    guard = 0;
    while (!taken && guard < 64) begin
      tick(1'b1, 32'hCAFEF00D, 1'b1, dsym(32'hCAFEF00D, 1'b1), taken);
      guard++;
    end
    tick(1'b0, 32'd0, 1'b0, 36'd0, taken);
    do_reset();
    idle(28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
